// File: rtl/eq_gain_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eq_gain_sequencer: loads per-band EQ gains, then gates samples into core   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module eq_gain_sequencer #(
  parameter int NBANDS   = 10,
  parameter int GW       = 4,
  parameter int MAX_GAIN = 12,
  parameter int DW       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [NBANDS*GW-1:0] gain_all,
  input  logic                 s_valid,
  input  logic [DW-1:0]        s_data,
  output logic                 s_ready,
  input  logic                 eq_in_ready,
  output logic                 eq_in_valid,
  output logic [DW-1:0]        eq_din,
  output logic                 eq_gainwe,
  output logic                 eq_gainset,
  output logic [3:0]           eq_band,
  output logic [GW-1:0]        eq_gain,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam logic [3:0]    C_LAST_BAND = 4'(NBANDS - 1);
  localparam logic [GW-1:0] C_MAX_GAIN  = GW'(MAX_GAIN);

  state_t               r_state, w_state_nxt;
  logic [3:0]           r_band_cnt, w_band_cnt_nxt;
  logic [NBANDS*GW-1:0] r_shadow, w_shadow_nxt;
  logic                 w_chg;
  logic                 w_load_nxt;
  logic                 w_commit_nxt;
  logic [GW-1:0]        w_code;
  logic [GW-1:0]        w_gain_nxt;

  function automatic logic [GW-1:0] band_code(input logic [NBANDS*GW-1:0] vec,
                                              input logic [3:0]           idx);
    band_code = '0;
    for (int k = 0; k < NBANDS; k++) begin
      if (idx == 4'(k)) band_code = vec[k*GW +: GW];
    end
  endfunction

  // The shadow copy is what was last loaded; any difference means the core is stale.
  assign w_chg       = (gain_all != r_shadow);
  assign s_ready     = (r_state == ST_RUN) && eq_in_ready && !w_chg;
  assign eq_in_valid = s_valid && s_ready;
  assign eq_din      = s_data;

  always_comb begin
    w_state_nxt    = r_state;
    w_band_cnt_nxt = r_band_cnt;
    w_shadow_nxt   = r_shadow;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt    = ST_LOAD;
          w_shadow_nxt   = gain_all;
          w_band_cnt_nxt = '0;
        end
      end
      ST_LOAD: begin
        if (r_band_cnt == C_LAST_BAND) begin
          w_state_nxt    = ST_COMMIT;
          w_band_cnt_nxt = '0;
        end else begin
          w_band_cnt_nxt = r_band_cnt + 4'd1;
        end
      end
      ST_COMMIT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_chg) begin
          w_state_nxt    = ST_LOAD;
          w_shadow_nxt   = gain_all;
          w_band_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Dropping enable abandons any partial load outright.
    if (!en) begin
      w_state_nxt    = ST_IDLE;
      w_band_cnt_nxt = '0;
    end
  end

  assign w_load_nxt   = (w_state_nxt == ST_LOAD);
  assign w_commit_nxt = (w_state_nxt == ST_COMMIT);
  assign w_code       = band_code(w_shadow_nxt, w_band_cnt_nxt);
  assign w_gain_nxt   = (w_code > C_MAX_GAIN) ? C_MAX_GAIN : w_code;

  // Core-facing controls are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_band_cnt <= '0;
      r_shadow   <= '0;
      eq_gainwe  <= 1'b0;
      eq_gainset <= 1'b0;
      eq_band    <= '0;
      eq_gain    <= '0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_band_cnt <= w_band_cnt_nxt;
      r_shadow   <= w_shadow_nxt;
      eq_gainwe  <= w_load_nxt;
      eq_gainset <= w_commit_nxt;
      eq_band    <= w_load_nxt ? w_band_cnt_nxt : 4'd0;
      eq_gain    <= w_load_nxt ? w_gain_nxt : '0;
      busy       <= w_load_nxt | w_commit_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eq_gain_sequencer.sv
`default_nettype none
// Scoreboard bench for eq_gain_sequencer: expected gain loads and samples are
// queued by the stimulus and consumed by an independent monitor.
module tb_eq_gain_sequencer;

  localparam int NBANDS   = 10;
  localparam int GW       = 4;
  localparam int MAX_GAIN = 12;
  localparam int DW       = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 en;
  logic [NBANDS*GW-1:0] gain_all;
  logic                 s_valid;
  logic [DW-1:0]        s_data;
  logic                 s_ready;
  logic                 eq_in_ready;
  logic                 eq_in_valid;
  logic [DW-1:0]        eq_din;
  logic                 eq_gainwe;
  logic                 eq_gainset;
  logic [3:0]           eq_band;
  logic [GW-1:0]        eq_gain;
  logic                 busy;

  eq_gain_sequencer #(
    .NBANDS(NBANDS), .GW(GW), .MAX_GAIN(MAX_GAIN), .DW(DW)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .gain_all(gain_all),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .eq_in_ready(eq_in_ready), .eq_in_valid(eq_in_valid), .eq_din(eq_din),
    .eq_gainwe(eq_gainwe), .eq_gainset(eq_gainset), .eq_band(eq_band),
    .eq_gain(eq_gain), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_set;
    int band;
    int gain;
  } ev_t;

  ev_t           exp_q[$];
  logic [DW-1:0] samp_q[$];
  int            checks = 0;
  int            passes = 0;
  int            rdy_mode = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int ref_gain(input logic [NBANDS*GW-1:0] g, input int k);
    int c;
    c = int'((g >> (GW * k)) & 40'hF);
    return (c > MAX_GAIN) ? MAX_GAIN : c;
  endfunction

  // Expected core-side view of a load: nb band writes, plus a commit if complete.
  task automatic push_load(input logic [NBANDS*GW-1:0] g, input int nb);
    for (int k = 0; k < nb; k++) exp_q.push_back('{is_set: 1'b0, band: k, gain: ref_gain(g, k)});
    if (nb == NBANDS) exp_q.push_back('{is_set: 1'b1, band: 0, gain: 0});
  endtask

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (eq_gainwe) begin
          if (exp_q.size() == 0) chk("unexpected_gainwe", eq_gainwe, 0);
          else begin
            e = exp_q.pop_front();
            chk("gainwe_vs_commit", 0, e.is_set);
            chk("eq_band", eq_band, e.band);
            chk("eq_gain", eq_gain, e.gain);
          end
        end
        if (eq_gainset) begin
          if (exp_q.size() == 0) chk("unexpected_gainset", eq_gainset, 0);
          else begin
            e = exp_q.pop_front();
            chk("gainset_vs_band", 1, e.is_set);
            chk("gainset_with_gainwe", eq_gainwe, 0);
          end
        end
        if (busy) chk("s_ready_while_busy", s_ready, 0);
        if (eq_in_valid) begin
          chk("valid_without_core_ready", eq_in_ready, 1);
          if (samp_q.size() == 0) chk("unexpected_sample", eq_in_valid, 0);
          else chk("eq_din", eq_din, samp_q.pop_front());
        end
      end
    end
  end

  initial begin : core_ready_driver
    eq_in_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       eq_in_ready = ~eq_in_ready;
        2:       eq_in_ready = 1'($urandom_range(0, 1));
        default: eq_in_ready = 1'b1;
      endcase
    end
  end

  // Called and returns at posedge+1; waits until every queued load event is seen.
  task automatic wait_load_done(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    chk("load_sequence_timeout", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (s_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("sample_accept_timeout", done, 1);
    s_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [DW-1:0] d, input int bound);
    samp_q.push_back(d);
    s_valid = 1'b1;
    s_data  = d;
    wait_accept(bound);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    logic [NBANDS*GW-1:0] g, g2;
    reset    = 1'b1;
    en       = 1'b0;
    gain_all = '0;
    s_valid  = 1'b0;
    s_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gainwe", eq_gainwe, 0);
    chk("rst_gainset", eq_gainset, 0);
    chk("rst_band", eq_band, 0);
    chk("rst_gain", eq_gain, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Ascending gains 0..9
    gain_all = 40'h9876543210;
    push_load(gain_all, NBANDS);
    en = 1'b1;
    wait_load_done(30);
    chk("run_busy", busy, 0);
    chk("run_s_ready", s_ready, 1);

    // Clamp of an over-range band, reloaded from RUN
    gain_all = 40'h000000F000;
    push_load(gain_all, NBANDS);
    wait_load_done(30);

    // Streaming with a toggling core ready
    rdy_mode = 1;
    for (int i = 1; i <= 8; i++) send_sample(16'(i), 20);
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Gain change with a sample pending: sample stalls across the reload
    gain_all = 40'h9876543210;
    push_load(gain_all, NBANDS);
    wait_load_done(30);
    g = gain_all;
    g[23:20] = 4'h7;
    push_load(g, NBANDS);
    samp_q.push_back(16'hA5A5);
    gain_all = g;
    s_valid  = 1'b1;
    s_data   = 16'hA5A5;
    @(negedge clk);
    chk("s_ready_on_change", s_ready, 0);
    @(posedge clk);
    #1;
    wait_accept(40);
    chk("reload_done_before_sample", exp_q.size(), 0);

    // Enable dropped at band 4
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    gain_all = 40'hCDEF012345;
    push_load(gain_all, 5);
    en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_gainwe", eq_gainwe, 0);
    chk("abort_gainset", eq_gainset, 0);
    chk("abort_band", eq_band, 0);
    chk("abort_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_partial_events", exp_q.size(), 0);
    push_load(gain_all, NBANDS);
    en = 1'b1;
    wait_load_done(30);

    // Asynchronous reset in the middle of a load
    g = 40'h1F2E3D4C5B;
    push_load(g, 3);
    gain_all = g;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_gainwe", eq_gainwe, 0);
    chk("async_rst_band", eq_band, 0);
    chk("async_rst_gain", eq_gain, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_partial_events", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    push_load(gain_all, NBANDS);
    reset = 1'b0;
    wait_load_done(30);

    // Randomized reloads (some changed again mid-load) and streams
    rdy_mode = 2;
    for (int it = 0; it < 8; it++) begin
      g = {8'($urandom), 32'($urandom)};
      if (g == gain_all) g = g ^ 40'h1;
      push_load(g, NBANDS);
      gain_all = g;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
        g2 = {8'($urandom), 32'($urandom)};
        if (g2 == g) g2 = g2 ^ 40'h10;
        push_load(g2, NBANDS);
        gain_all = g2;
      end
      wait_load_done(60);
      for (int j = 0; j < 5; j++) send_sample(16'($urandom), 50);
    end
    rdy_mode = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("load_queue_drained", exp_q.size(), 0);
    chk("sample_queue_drained", samp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
